rf_writeback_stage: RTL and testbench
=====================================

RF_WRITEBACK_STAGE -- requirements
Module: rf_writeback_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath and register width in bits.
REQ-002 SHALL have parameter RA_W, default 5, meaning register-file address width.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  meaning the upstream instruction is valid.
REQ-006 SHALL have port in_ready  output  1  meaning the block accepts an instruction this cycle.
REQ-007 SHALL have port opcode  input  7  meaning the RV32I opcode of the offered instruction.
REQ-008 SHALL have port funct3  input  3  meaning the load size and sign select.
REQ-009 SHALL have port rd_addr  input  RA_W  meaning the destination register.
REQ-010 SHALL have port alu_out  input  XLEN  meaning the ALU result.
REQ-011 SHALL have port pc_plus_4  input  XLEN  meaning the link value.
REQ-012 SHALL have port addr_lsb  input  2  meaning the low bits of the load address.
REQ-013 SHALL have port mem_rdata  input  XLEN  meaning the raw load word.
REQ-014 SHALL have port mem_rvalid  input  1  meaning mem_rdata is valid this cycle.
REQ-015 SHALL have port flush  input  1  meaning discard the pending load and the staged write.
REQ-016 SHALL have port rf_we  output  1  meaning the register-file write enable.
REQ-017 SHALL have port rf_waddr  output  RA_W  meaning the register-file write address.
REQ-018 SHALL have port rf_wdata  output  XLEN  meaning the register-file write data.
REQ-019 SHALL have port busy  output  1  meaning a load is outstanding.

Function
REQ-020 SHALL implement states IDLE and WAIT_LOAD, and SHALL drive in_ready = (state==IDLE) && !flush.
REQ-021 SHALL treat an instruction as accepted when in_valid && in_ready.
REQ-022 On acceptance in IDLE, SHALL behave as follows for each opcode:
- R (0110011), I (0010011), AUIPC (0010111), LUI (0110111): register alu_out and assert rf_we the next cycle.
- JALR (1100111), JAL (1101111): register pc_plus_4 and assert rf_we the next cycle.
- LOAD (0000011): latch rd_addr, funct3 and addr_lsb, then enter WAIT_LOAD.
- Any other opcode: accept and perform no write.
REQ-023 SHALL give one-cycle latency for non-load writes and SHALL sustain back-to-back acceptance (one instruction per cycle).
REQ-024 SHALL hold busy = 1 in WAIT_LOAD.
REQ-025 SHALL ignore mem_rvalid in IDLE.
REQ-026 On mem_rvalid in WAIT_LOAD, SHALL register the aligned load data, assert rf_we the next cycle, and return to IDLE.
REQ-027 SHALL align load data as follows:
- LB/LBU (000/100): byte mem_rdata[8*addr_lsb +: 8], sign- or zero-extended to XLEN.
- LH/LHU (001/101): halfword selected by addr_lsb[1], sign- or zero-extended.
- LW (010) and any other funct3: the full word.
REQ-028 SHALL force rf_we = 0 whenever the destination is register 0, for every write source.
REQ-029 SHALL deassert rf_we in every cycle with no new write, so that rf_we is a single-cycle pulse per write.
REQ-030 SHALL hold rf_waddr and rf_wdata stable while rf_we = 0.
REQ-031 On flush, SHALL clear rf_we next cycle, go to IDLE, and ignore any mem_rvalid arriving in the same cycle.
REQ-032 SHALL give flush priority over both acceptance and mem_rvalid.

Reset
REQ-033 While rst_n = 0, SHALL force state IDLE and rf_we = 0, busy = 0, rf_waddr = 0, rf_wdata = 0, and in_ready = 0.
REQ-034 SHALL assert in_ready in the first cycle after rst_n deasserts.
REQ-035 On reset during WAIT_LOAD, SHALL abandon the pending load with no write produced.

Verification
REQ-036 R-type with rd=5 and alu_out=0x0000_1234 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x0000_1234; the cycle after, rf_we=0.
REQ-037 JAL with rd=1 and pc_plus_4=0x0000_0104, followed back-to-back by LUI with rd=2 and alu_out=0xABCD_E000 -> two consecutive rf_we pulses carrying 0x104 and 0xABCDE000.
REQ-038 LB with addr_lsb=3 and rd=7, mem_rdata=0x80FF_FF7F returned 3 cycles later -> busy=1 and in_ready=0 for 3 cycles; then rf_wdata=0xFFFF_FF80 on rd 7; as LBU the result is 0x0000_0080.
REQ-039 LH with addr_lsb=2 and mem_rdata=0x8001_0000 -> rf_wdata=0xFFFF_8001; I-type with rd=0 -> rf_we stays 0.
REQ-040 LW pending, then flush and mem_rvalid asserted in the same cycle -> no rf_we, state IDLE, in_ready=1 the next cycle.
REQ-041 rst_n pulsed low during WAIT_LOAD -> all outputs 0 immediately; a later mem_rvalid produces no write.

Source files
------------

// File: rtl/rf_writeback_stage.sv
// rf_writeback_stage: register-file writeback with load alignment.
// Ports: handshake (in_valid/in_ready), instruction fields (opcode,
// funct3, rd_addr, alu_out, pc_plus_4, addr_lsb), memory return
// (mem_rdata/mem_rvalid), flush, RF write (rf_we/rf_waddr/rf_wdata), busy.
module rf_writeback_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [RA_W-1:0] rd_addr,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] pc_plus_4,
  input  logic [1:0]      addr_lsb,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_rvalid,
  input  logic            flush,
  output logic            rf_we,
  output logic [RA_W-1:0] rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            busy
);

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;

  state_e          state_q, state_d;
  logic [RA_W-1:0] ld_rd_q, ld_rd_d;
  logic [2:0]      ld_f3_q, ld_f3_d;
  logic [1:0]      ld_lsb_q, ld_lsb_d;
  logic            rf_we_q, rf_we_d;
  logic [RA_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

  logic            accept;
  logic            is_alu, is_jmp, is_load;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;

  // rst_n gates in_ready so nothing is offered while reset is held.
  assign in_ready = rst_n && (state_q == IDLE) && !flush;
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q == WAIT_LOAD);

  assign is_alu  = (opcode == OP_R) || (opcode == OP_I) ||
                   (opcode == OP_AUIPC) || (opcode == OP_LUI);
  assign is_jmp  = (opcode == OP_JALR) || (opcode == OP_JAL);
  assign is_load = (opcode == OP_LOAD);

  assign ld_byte = mem_rdata[{ld_lsb_q, 3'b000} +: 8];
  assign ld_half = mem_rdata[{ld_lsb_q[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = mem_rdata;
    unique case (ld_f3_q)
      3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  // Address/data only move on a real write so they stay
  // stable whenever rf_we is low (x0 writes included).
  always_comb begin
    state_d    = state_q;
    ld_rd_d    = ld_rd_q;
    ld_f3_d    = ld_f3_q;
    ld_lsb_d   = ld_lsb_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (flush) begin
      state_d = IDLE;
    end else if (accept) begin
      unique case (1'b1)
        is_alu: begin
          if (rd_addr != '0) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = rd_addr;
            rf_wdata_d = alu_out;
          end
        end
        is_jmp: begin
          if (rd_addr != '0) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = rd_addr;
            rf_wdata_d = pc_plus_4;
          end
        end
        is_load: begin
          ld_rd_d  = rd_addr;
          ld_f3_d  = funct3;
          ld_lsb_d = addr_lsb;
          state_d  = WAIT_LOAD;
        end
        default: ;
      endcase
    end else if (state_q == WAIT_LOAD && mem_rvalid) begin
      state_d = IDLE;
      if (ld_rd_q != '0) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = ld_rd_q;
        rf_wdata_d = ld_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ld_rd_q    <= '0;
      ld_f3_q    <= '0;
      ld_lsb_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      ld_rd_q    <= ld_rd_d;
      ld_f3_q    <= ld_f3_d;
      ld_lsb_q   <= ld_lsb_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_rf_writeback_stage.sv
// tb_rf_writeback_stage: directed vectors and load/flush/reset
// sequences for rf_writeback_stage.
module tb_rf_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [4:0]  rd_addr = '0;
  logic [31:0] alu_out = '0;
  logic [31:0] pc_plus_4 = '0;
  logic [1:0]  addr_lsb = '0;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic        flush = 1'b0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  rf_writeback_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .rd_addr(rd_addr),
    .alu_out(alu_out), .pc_plus_4(pc_plus_4),
    .addr_lsb(addr_lsb), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .flush(flush),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input string nm, input logic [2:0] f3,
                         input logic [1:0] lsb, input logic [4:0] rd,
                         input logic [31:0] rdata, input int dly,
                         input logic e_we, input logic [4:0] e_addr,
                         input logic [31:0] e_data);
    in_valid = 1'b1; opcode = 7'b0000011; funct3 = f3;
    addr_lsb = lsb; rd_addr = rd;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < dly; c++) begin
      chk({nm, " busy"}, {31'b0, busy}, 32'd1);
      chk({nm, " in_ready"}, {31'b0, in_ready}, 32'd0);
      chk({nm, " we wait"}, {31'b0, rf_we}, 32'd0);
      if (c < dly - 1) tick();
    end
    mem_rdata = rdata; mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    chk({nm, " we"}, {31'b0, rf_we}, {31'b0, e_we});
    chk({nm, " waddr"}, {27'b0, rf_waddr}, {27'b0, e_addr});
    chk({nm, " wdata"}, rf_wdata, e_data);
    chk({nm, " busy done"}, {31'b0, busy}, 32'd0);
    tick();
    chk({nm, " we pulse"}, {31'b0, rf_we}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{7'b0110011, 5'd5,  32'h0000_1234, 32'h0,
                1'b1, 5'd5, 32'h0000_1234};
    vecs[1] = '{7'b1101111, 5'd1,  32'h0,         32'h0000_0104,
                1'b1, 5'd1, 32'h0000_0104};
    vecs[2] = '{7'b0110111, 5'd2,  32'hABCD_E000, 32'h0,
                1'b1, 5'd2, 32'hABCD_E000};
    vecs[3] = '{7'b0010011, 5'd0,  32'h0000_0055, 32'h0,
                1'b0, 5'd2, 32'hABCD_E000};
    vecs[4] = '{7'b0100011, 5'd3,  32'h1111_1111, 32'h0,
                1'b0, 5'd2, 32'hABCD_E000};
    vecs[5] = '{7'b0010111, 5'd31, 32'h8000_0010, 32'h0,
                1'b1, 5'd31, 32'h8000_0010};
    vecs[6] = '{7'b1100111, 5'd4,  32'h0000_DEAD, 32'h0000_0200,
                1'b1, 5'd4, 32'h0000_0200};
    vecs[7] = '{7'b1100011, 5'd6,  32'h2222_2222, 32'h0,
                1'b0, 5'd4, 32'h0000_0200};
    vecs[8] = '{7'b0010011, 5'd8,  32'hFFFF_FFFF, 32'h0,
                1'b1, 5'd8, 32'hFFFF_FFFF};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst we", {31'b0, rf_we}, 32'd0);
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst waddr", {27'b0, rf_waddr}, 32'd0);
    chk("rst wdata", rf_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-rst in_ready", {31'b0, in_ready}, 32'd1);

    // back-to-back table
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; opcode = vecs[i].op; rd_addr = vecs[i].rd;
      alu_out = vecs[i].alu; pc_plus_4 = vecs[i].pc4;
      tick();
      chk($sformatf("v%0d we", i), {31'b0, rf_we}, {31'b0, vecs[i].e_we});
      chk($sformatf("v%0d waddr", i), {27'b0, rf_waddr},
          {27'b0, vecs[i].e_addr});
      chk($sformatf("v%0d wdata", i), rf_wdata, vecs[i].e_data);
      chk($sformatf("v%0d in_ready", i), {31'b0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("idle we", {31'b0, rf_we}, 32'd0);
    chk("idle wdata hold", rf_wdata, 32'hFFFF_FFFF);

    // mem_rvalid ignored in IDLE
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    mem_rvalid = 1'b0;
    chk("idle rvalid we", {31'b0, rf_we}, 32'd0);
    chk("idle rvalid busy", {31'b0, busy}, 32'd0);

    // loads
    do_load("lb",  3'b000, 2'd3, 5'd7,  32'h80FF_FF7F, 3,
            1'b1, 5'd7,  32'hFFFF_FF80);
    do_load("lbu", 3'b100, 2'd3, 5'd7,  32'h80FF_FF7F, 3,
            1'b1, 5'd7,  32'h0000_0080);
    do_load("lb1", 3'b000, 2'd1, 5'd11, 32'h80FF_FF7F, 1,
            1'b1, 5'd11, 32'hFFFF_FFFF);
    do_load("lbu0", 3'b100, 2'd0, 5'd12, 32'h80FF_FF7F, 2,
            1'b1, 5'd12, 32'h0000_007F);
    do_load("lh",  3'b001, 2'd2, 5'd9,  32'h8001_0000, 2,
            1'b1, 5'd9,  32'hFFFF_8001);
    do_load("lhu", 3'b101, 2'd2, 5'd9,  32'h8001_0000, 1,
            1'b1, 5'd9,  32'h0000_8001);
    do_load("lh0", 3'b001, 2'd0, 5'd14, 32'h1234_F00D, 1,
            1'b1, 5'd14, 32'hFFFF_F00D);
    do_load("lw",  3'b010, 2'd0, 5'd10, 32'h1234_5678, 2,
            1'b1, 5'd10, 32'h1234_5678);
    do_load("lx3", 3'b011, 2'd1, 5'd15, 32'h8765_4321, 1,
            1'b1, 5'd15, 32'h8765_4321);
    do_load("ld_x0", 3'b010, 2'd0, 5'd0, 32'hCAFE_F00D, 1,
            1'b0, 5'd15, 32'h8765_4321);

    // flush with mem_rvalid while a load is pending
    in_valid = 1'b1; opcode = 7'b0000011; funct3 = 3'b010; rd_addr = 5'd13;
    tick();
    in_valid = 1'b0;
    chk("fl busy", {31'b0, busy}, 32'd1);
    flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("fl in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    flush = 1'b0; mem_rvalid = 1'b0;
    chk("fl we", {31'b0, rf_we}, 32'd0);
    chk("fl busy clr", {31'b0, busy}, 32'd0);
    chk("fl wdata hold", rf_wdata, 32'h8765_4321);
    #1;
    chk("fl in_ready after", {31'b0, in_ready}, 32'd1);

    // flush beats acceptance
    flush = 1'b1; in_valid = 1'b1; opcode = 7'b0110011;
    rd_addr = 5'd20; alu_out = 32'h0BAD_0BAD;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl acc we", {31'b0, rf_we}, 32'd0);
    chk("fl acc wdata", rf_wdata, 32'h8765_4321);

    // reset during WAIT_LOAD
    in_valid = 1'b1; opcode = 7'b0000011; funct3 = 3'b010; rd_addr = 5'd13;
    tick();
    in_valid = 1'b0;
    chk("wrst busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("wrst busy0", {31'b0, busy}, 32'd0);
    chk("wrst waddr0", {27'b0, rf_waddr}, 32'd0);
    chk("wrst wdata0", rf_wdata, 32'd0);
    chk("wrst in_ready0", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    mem_rvalid = 1'b0;
    chk("wrst late we", {31'b0, rf_we}, 32'd0);
    chk("wrst late wdata", rf_wdata, 32'd0);
    chk("wrst in_ready", {31'b0, in_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
